// File: rtl/roi_stream_ctrl.sv
// rtl/roi_stream_ctrl.sv - ROI frame sequencer: feeds sobel_conv, flushes it, and
// turns max_mask result beats into addressed writes over the unmasked region.
module roi_stream_ctrl #(
    parameter int ROI_SIZE             = 64,
    parameter int PORT_BITS            = 128,
    parameter int IN_WIDTH             = 8,
    parameter int OUT_WIDTH            = 12,
    parameter int MASK_SIZE            = 6,
    parameter int PIXELS_OUT_PER_CYCLE = 2,
    parameter int FLUSH_MAX            = 1024,
    localparam int AW                  = $clog2(ROI_SIZE*ROI_SIZE)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clk_en,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err,
    input  logic                                      src_valid,
    input  logic [PORT_BITS-1:0]                      src_data,
    output logic                                      src_ready,
    input  logic                                      conv_ready,
    output logic [PORT_BITS-1:0]                      conv_din,
    output logic                                      dp_clk_en,
    input  logic                                      res_valid,
    input  logic [PIXELS_OUT_PER_CYCLE*OUT_WIDTH-1:0] res_data,
    output logic                                      wr_en,
    output logic [AW-1:0]                             wr_addr,
    output logic [PIXELS_OUT_PER_CYCLE*OUT_WIDTH-1:0] wr_data
);
    localparam int P     = PIXELS_OUT_PER_CYCLE;
    localparam int RW    = P*OUT_WIDTH;
    localparam int WORDS = ROI_SIZE*ROI_SIZE*IN_WIDTH/PORT_BITS;
    localparam int WCW   = $clog2(WORDS+1);
    localparam int CW    = $clog2(ROI_SIZE+1);
    localparam int IW    = $clog2(FLUSH_MAX+1);

    localparam logic [WCW-1:0] W_LAST     = WCW'(WORDS-1);
    localparam logic [WCW-1:0] W_ONE      = WCW'(1);
    localparam logic [CW-1:0]  C_P        = CW'(P);
    localparam logic [CW-1:0]  C_ROI      = CW'(ROI_SIZE);
    localparam logic [CW-1:0]  C_MASK     = CW'(MASK_SIZE);
    localparam logic [CW-1:0]  C_LAST_ROW = CW'(ROI_SIZE-1);
    localparam logic [CW-1:0]  C_ONE      = CW'(1);
    localparam logic [AW-1:0]  A_START    = AW'(ROI_SIZE*MASK_SIZE+MASK_SIZE);
    localparam logic [AW-1:0]  A_P        = AW'(P);
    localparam logic [AW-1:0]  A_WRAP     = AW'(P+MASK_SIZE);
    localparam logic [IW-1:0]  I_LAST     = IW'(FLUSH_MAX-1);
    localparam logic [IW-1:0]  I_ONE      = IW'(1);

    if (((ROI_SIZE-MASK_SIZE) % PIXELS_OUT_PER_CYCLE != 0) || (PORT_BITS % IN_WIDTH != 0)) begin : g_param_check
        $error("roi_stream_ctrl: unsupported parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_timeout;
    logic            w_active;
    logic            w_beat;
    logic            w_row_end;
    logic [WCW-1:0]  r_word_cnt;
    logic [CW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [AW-1:0]   r_out_idx;
    logic [IW-1:0]   r_idle_cnt;
    logic            r_err;
    logic            r_last_wr;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [RW-1:0]   r_wr_data;

    assign w_active  = (r_state == S_FEED) || (r_state == S_FLUSH);
    // r_last_wr closes the result window so done lands the cycle after the final write
    assign w_beat    = w_active && clk_en && res_valid && !r_last_wr;
    assign w_row_end = (r_col + C_P) == C_ROI;

    assign src_ready = (r_state == S_FEED) && clk_en && conv_ready && src_valid;
    assign conv_din  = (r_state == S_FEED) ? src_data : '0;
    assign dp_clk_en = clk_en && !((r_state == S_FEED) && conv_ready && !src_valid);
    assign busy      = w_active;
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && clk_en) begin
                    w_state_nxt = S_FEED;
                    w_accept    = 1'b1;
                end
            end
            S_FEED: begin
                if (clk_en) begin
                    if (r_last_wr)
                        w_state_nxt = S_DONE;
                    else if (src_ready && (r_word_cnt == W_LAST))
                        w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (clk_en) begin
                    if (r_last_wr) begin
                        w_state_nxt = S_DONE;
                    end else if (!res_valid && (r_idle_cnt == I_LAST)) begin
                        w_state_nxt = S_DONE;
                        w_timeout   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (clk_en)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_out_idx  <= '0;
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
            r_last_wr  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_beat;
            if (w_accept) begin
                r_word_cnt <= '0;
                r_row      <= C_MASK;
                r_col      <= C_MASK;
                r_out_idx  <= A_START;
                r_idle_cnt <= '0;
                r_err      <= 1'b0;
                r_last_wr  <= 1'b0;
            end else begin
                if (src_ready)
                    r_word_cnt <= r_word_cnt + W_ONE;
                if (w_beat) begin
                    r_wr_addr  <= r_out_idx;
                    r_wr_data  <= res_data;
                    r_idle_cnt <= '0;
                    if (w_row_end) begin
                        r_col     <= C_MASK;
                        r_row     <= r_row + C_ONE;
                        r_out_idx <= r_out_idx + A_WRAP;
                        if (r_row == C_LAST_ROW)
                            r_last_wr <= 1'b1;
                    end else begin
                        r_col     <= r_col + C_P;
                        r_out_idx <= r_out_idx + A_P;
                    end
                end else if (clk_en && (r_state == S_FLUSH) && !r_last_wr) begin
                    r_idle_cnt <= r_idle_cnt + I_ONE;
                end
                if (w_timeout)
                    r_err <= 1'b1;
                if (clk_en && (r_state == S_DONE))
                    r_last_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_roi_stream_ctrl.sv
// tb/tb_roi_stream_ctrl.sv - directed bench for roi_stream_ctrl: full frame, starvation,
// random clk_en, flush timeout, start-while-busy and mid-frame reset.
module tb_roi_stream_ctrl;
    localparam int ROI   = 64;
    localparam int MASK  = 6;
    localparam int P     = 2;
    localparam int BPR   = (ROI-MASK)/P;
    localparam int BEATS = (ROI-MASK)*(ROI-MASK)/P;
    localparam int WORDS = 256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_en;
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic         src_valid;
    logic [127:0] src_data;
    logic         src_ready;
    logic         conv_ready;
    logic [127:0] conv_din;
    logic         dp_clk_en;
    logic         res_valid;
    logic [23:0]  res_data;
    logic         wr_en;
    logic [11:0]  wr_addr;
    logic [23:0]  wr_data;

    roi_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
        .busy(busy), .done(done), .err(err),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .conv_ready(conv_ready), .conv_din(conv_din), .dp_clk_en(dp_clk_en),
        .res_valid(res_valid), .res_data(res_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] wa [2048];
    logic [23:0] wd [2048];
    logic [23:0] ref_wd [2048];
    int fed, beats, flush_beats, drop, nw, done_cyc, last_wr_cyc, n_done, idle;
    int dp_low, dp_bad, sr_bad, din_bad, ce_bad, addr_bad, data_bad, ref_bad;
    logic err_at_done, busy_at_done, done_after;
    bit finished, prev_ce, in_flush;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] word_pat(input int i);
        logic [31:0] h;
        h = 32'(i) * 32'h9E3779B1 + 32'd7;
        return {h, ~h, h ^ 32'h5A5A5A5A, 32'(i)};
    endfunction

    function automatic logic [23:0] res_pat(input int k);
        logic [23:0] v;
        v = 24'(k) * 24'h00F1E3;
        return v ^ 24'h0A5C35;
    endfunction

    function automatic int exp_addr(input int k);
        return (MASK + k/BPR)*ROI + MASK + P*(k%BPR);
    endfunction

    task automatic score_writes();
        addr_bad = 0; data_bad = 0; ref_bad = 0;
        for (int k = 0; k < nw && k < 2048; k++) begin
            if (wa[k] !== 12'(exp_addr(k))) addr_bad++;
            if (wd[k] !== res_pat(k)) data_bad++;
            if (wd[k] !== ref_wd[k]) ref_bad++;
        end
    endtask

    // mode 0/5 plain, 1 starvation + stray start, 2 random clk_en, 3 flush timeout, 4 reset at word 50
    task run_frame(input int mode);
        fed = 0; beats = 0; flush_beats = 0; drop = 0; nw = 0; n_done = 0; idle = 0;
        done_cyc = -1; last_wr_cyc = -1; dp_low = 0; dp_bad = 0; sr_bad = 0; din_bad = 0; ce_bad = 0;
        err_at_done = 1'bx; busy_at_done = 1'bx; done_after = 1'bx;
        prev_ce = 1'b1; finished = 1'b0;
        @(negedge clk);
        clk_en = 1'b1; start = 1'b1; src_valid = 1'b1; src_data = word_pat(0);
        res_valid = 1'b0; conv_ready = 1'b1;
        @(posedge clk); #1;
        check($sformatf("m%0d_busy_rise", mode), busy, 1);
        check($sformatf("m%0d_start_err_clear", mode), err, 0);
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            start     = (mode == 1 && fed == 10);
            clk_en    = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            src_valid = 1'b1;
            if (mode == 1 && fed == 100 && drop < 5) begin
                src_valid = 1'b0;
                drop++;
            end
            src_data  = word_pat(fed);
            in_flush  = (fed == WORDS);
            res_valid = busy && fed >= 20 && beats < BEATS && !(mode == 3 && flush_beats >= 100);
            res_data  = res_pat(beats);
            if (mode == 4 && fed == 50) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_mid_busy", busy, 0);
                check("rst_mid_done", done, 0);
                check("rst_mid_wr_en", wr_en, 0);
                check("rst_mid_wr_addr", wr_addr, 0);
                check("rst_mid_src_ready", src_ready, 0);
                check("rst_mid_conv_din_zero", (conv_din == '0), 1);
                check("rst_mid_dp_clk_en", dp_clk_en, 1);
                @(negedge clk);
                rst_n = 1'b1; start = 1'b0; res_valid = 1'b0;
                finished = 1'b1;
            end else begin
                #1;
                if (wr_en) begin
                    if (!prev_ce) ce_bad++;
                    if (nw < 2048) begin
                        wa[nw] = wr_addr;
                        wd[nw] = wr_data;
                    end
                    nw++;
                    last_wr_cyc = cyc;
                end
                if (!clk_en && (src_ready || dp_clk_en)) ce_bad++;
                if (clk_en && !dp_clk_en) dp_low++;
                if (clk_en && !dp_clk_en && src_valid) dp_bad++;
                if (!src_valid && src_ready) sr_bad++;
                if (busy && fed < WORDS && conv_din !== src_data) din_bad++;
                if (busy && fed == WORDS && conv_din !== '0) din_bad++;
                if (busy && fed == WORDS && !res_valid && clk_en) idle++;
                if (src_ready) fed++;
                if (res_valid && clk_en) begin
                    beats++;
                    if (in_flush) flush_beats++;
                end
                prev_ce = clk_en;
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                    err_at_done = err;
                    busy_at_done = busy;
                    finished = 1'b1;
                    clk_en = 1'b1; res_valid = 1'b0; start = 1'b0;
                end
            end
        end
        if (!finished) check($sformatf("m%0d_frame_budget", mode), 0, 1);
        else if (mode != 4) begin
            @(negedge clk); #1;
            done_after = done;
        end
        score_writes();
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
        conv_ready = 1'b1; res_valid = 1'b0; res_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_conv_din_zero", (conv_din == '0), 1);
        check("rst_dp_clk_en", dp_clk_en, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0);
        check("f0_handshakes", fed, WORDS);
        check("f0_writes", nw, BEATS);
        check("f0_addr_first", wa[0], 390);
        check("f0_addr_second", wa[1], 392);
        check("f0_addr_29th", wa[28], 446);
        check("f0_addr_30th", wa[29], 454);
        check("f0_addr_last", wa[BEATS-1], 4094);
        check("f0_addr_seq_bad", addr_bad, 0);
        check("f0_data_bad", data_bad, 0);
        check("f0_conv_din_bad", din_bad, 0);
        check("f0_done_count", n_done, 1);
        check("f0_done_after_last_wr", done_cyc, last_wr_cyc + 1);
        check("f0_busy_at_done", busy_at_done, 0);
        check("f0_err_at_done", err_at_done, 0);
        check("f0_done_one_cycle", done_after, 0);
        for (int k = 0; k < 2048; k++) ref_wd[k] = wd[k];

        run_frame(1);
        check("f1_handshakes", fed, WORDS);
        check("f1_dp_low_cycles", dp_low, 5);
        check("f1_dp_low_with_valid", dp_bad, 0);
        check("f1_ready_without_valid", sr_bad, 0);
        check("f1_writes", nw, BEATS);
        check("f1_addr_seq_bad", addr_bad, 0);
        check("f1_data_vs_unstalled", ref_bad, 0);
        check("f1_done_count", n_done, 1);

        run_frame(2);
        check("f2_handshakes", fed, WORDS);
        check("f2_writes", nw, BEATS);
        check("f2_addr_seq_bad", addr_bad, 0);
        check("f2_data_vs_unstalled", ref_bad, 0);
        check("f2_clk_en_low_activity", ce_bad, 0);
        check("f2_addr_last", wa[BEATS-1], 4094);

        run_frame(3);
        check("f3_flush_beats", flush_beats, 100);
        check("f3_writes", nw, beats);
        check("f3_addr_seq_bad", addr_bad, 0);
        check("f3_idle_cycles", idle, 1024);
        check("f3_err_at_done", err_at_done, 1);
        check("f3_done_count", n_done, 1);
        check("f3_err_sticky", err, 1);

        run_frame(4);
        check("f4_no_done", n_done, 0);
        #1;
        check("f4_post_rst_busy", busy, 0);
        check("f4_post_rst_err", err, 0);

        run_frame(5);
        check("f5_addr_first", wa[0], 390);
        check("f5_writes", nw, BEATS);
        check("f5_addr_seq_bad", addr_bad, 0);
        check("f5_done_after_last_wr", done_cyc, last_wr_cyc + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
